// File: rtl/stepper_motion_ctrl.sv
// Single-axis stepper core: wave/full/half coil sequencing driven either by a
// rate-limited internal target mover or by synchronised external STEP/DIR pins.
module stepper_motion_ctrl #(
  parameter int POS_W       = 32,
  parameter int DIV_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    src_ext,
  input  logic                    ext_step,
  input  logic                    ext_dir,
  input  logic signed [POS_W-1:0] target_pos,
  input  logic                    target_load,
  input  logic [DIV_W-1:0]        period,
  input  logic                    zero_pos,
  output logic signed [POS_W-1:0] cur_pos,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              coil_out
);

  typedef enum logic {
    S_IDLE,
    S_MOVING
  } state_t;

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t state;
  state_t state_nxt;

  logic signed [POS_W-1:0] target;
  logic signed [POS_W-1:0] target_nxt;
  logic signed [POS_W-1:0] pos_nxt;
  logic signed [POS_W-1:0] pos_step;
  logic [DIV_W-1:0]        divider;
  logic [DIV_W-1:0]        div_nxt;
  logic [2:0]              phase;
  logic [2:0]              phase_nxt;
  logic [2:0]              phase_step;
  logic [2:0]              phase_inc;
  logic [2:0]              table_idx;
  logic [3:0]              coil_pat;
  logic                    done_nxt;

  logic [SYNC_STAGES-1:0]  step_sync;
  logic [SYNC_STAGES-1:0]  dir_sync;
  logic                    step_hist;
  logic                    ext_rise;
  logic                    step_fwd;
  logic                    busy_tick;

  function automatic logic [3:0] half_table(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Wave and full modes pin the low index bit, so switching modes mid-move
  // always lands on a legal pattern for the new mode.
  always_comb begin
    case (mode)
      2'b10:   table_idx = phase;
      2'b00:   table_idx = {phase[2:1], 1'b0};
      default: table_idx = {phase[2:1], 1'b1};
    endcase
    coil_pat = half_table(table_idx);
  end

  assign ext_rise  = step_sync[SYNC_STAGES-1] & ~step_hist;
  assign busy_tick = (state == S_MOVING) && enable;

  always_comb begin
    if (src_ext) begin
      step_fwd = dir_sync[SYNC_STAGES-1];
    end else begin
      step_fwd = (target > cur_pos);
    end
    phase_inc  = (mode == 2'b10) ? 3'd1 : 3'd2;
    pos_step   = step_fwd ? (cur_pos + POS_ONE) : (cur_pos - POS_ONE);
    phase_step = step_fwd ? (phase + phase_inc) : (phase - phase_inc);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath: zero_pos outranks target_load, which outranks a step
  always_comb begin
    state_nxt  = state;
    pos_nxt    = cur_pos;
    phase_nxt  = phase;
    target_nxt = target;
    div_nxt    = divider;
    done_nxt   = 1'b0;
    if (src_ext) begin
      state_nxt = S_IDLE;
      if (zero_pos) begin
        pos_nxt = '0;
      end else if (enable && ext_rise) begin
        pos_nxt   = pos_step;
        phase_nxt = phase_step;
      end
    end else begin
      if (busy_tick) begin
        div_nxt = (divider == '0) ? period : (divider - DIV_ONE);
      end
      if (zero_pos) begin
        pos_nxt = '0;
        if ((state == S_MOVING) && (target == '0)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end else if (target_load) begin
        target_nxt = target_pos;
        if (target_pos == cur_pos) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = S_MOVING;
          if (state == S_IDLE) begin
            div_nxt = period;
          end
        end
      end else if (busy_tick && (divider == '0)) begin
        pos_nxt   = pos_step;
        phase_nxt = phase_step;
        if (pos_step == target) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == S_MOVING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pos   <= '0;
      phase     <= '0;
      target    <= '0;
      divider   <= '0;
      done      <= 1'b0;
      coil_out  <= 4'b0000;
      step_sync <= '0;
      dir_sync  <= '0;
      step_hist <= 1'b0;
    end else begin
      cur_pos   <= pos_nxt;
      phase     <= phase_nxt;
      target    <= target_nxt;
      divider   <= div_nxt;
      done      <= done_nxt;
      coil_out  <= enable ? coil_pat : 4'b0000;
      step_sync <= {step_sync[SYNC_STAGES-2:0], ext_step};
      dir_sync  <= {dir_sync[SYNC_STAGES-2:0], ext_dir};
      step_hist <= step_sync[SYNC_STAGES-1];
    end
  end

endmodule
